// File: rtl/pd_ctrl_pkg.sv
// Shared types, widths and saturation helper for the PD balance loop.
package pd_ctrl_pkg;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 33;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SENSOR,
        CALC_ERR,
        MUL_P,
        MUL_D,
        SATURATE
    } pd_state_t;

    // Saturate a wide signed value to DATA_W bits.
    function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [ACC_W-1:0] x);
        if ((&x[ACC_W-1:DATA_W-1]) || !(|x[ACC_W-1:DATA_W-1]))
            return x[DATA_W-1:0];
        return x[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    endfunction

endpackage

// File: rtl/pd_mul16.sv
// Combinational signed 16x16 -> 32 multiplier shared by the P and D terms.
module pd_mul16 (
    input  logic signed [15:0] a,
    input  logic signed [15:0] b,
    output logic signed [31:0] p
);

    assign p = a * b;

endmodule

// File: rtl/pd_loop_sequencer.sv
// Periodic PD control sequencer: period tick, sensor handshake, time-shared
// multiply, output saturation and PWM publish with a one-cycle valid strobe.
module pd_loop_sequencer
    import pd_ctrl_pkg::*;
#(
    parameter int PERIOD  = 1000,
    parameter int TIMEOUT = 64,
    parameter int SHIFT   = 0,
    parameter int PWM_MAX = 7000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] setpoint,
    input  logic signed [DATA_W-1:0] kp,
    input  logic signed [DATA_W-1:0] kd,
    output logic                     sample_req,
    input  logic                     sensor_valid,
    input  logic signed [DATA_W-1:0] sensor,
    output logic signed [DATA_W-1:0] pwm,
    output logic                     pwm_valid,
    output logic                     busy,
    output logic                     timeout_flag,
    output logic                     overrun_flag,
    input  logic                     clr_flags
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic signed [DATA_W-1:0] PWM_HI = DATA_W'(PWM_MAX);
    localparam logic signed [DATA_W-1:0] PWM_LO = DATA_W'(-PWM_MAX);

    function automatic logic signed [DATA_W-1:0] clamp_pwm(input logic signed [DATA_W-1:0] x);
        if (x > PWM_HI) return PWM_HI;
        if (x < PWM_LO) return PWM_LO;
        return x;
    endfunction

    pd_state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [TO_W-1:0]  wcnt;
    logic             tick, hs, to_evt, ov_evt;
    logic             first_sample;

    logic signed [DATA_W-1:0]   sensor_q, bias, d_bias, last_bias;
    logic signed [DATA_W-1:0]   bias_nxt, d_bias_nxt, pwm_nxt;
    logic signed [ACC_W-1:0]    err_wide, d_wide, acc, acc_shr, prod_ext;
    logic signed [DATA_W-1:0]   mul_a, mul_b;
    logic signed [2*DATA_W-1:0] prod;

    assign tick       = en && (cnt == CNT_W'(PERIOD - 1));
    assign sample_req = (state == WAIT_SENSOR);
    assign busy       = (state != IDLE);
    assign ov_evt     = tick && (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        hs        = 1'b0;
        to_evt    = 1'b0;
        case (state)
            IDLE:        if (tick) state_nxt = WAIT_SENSOR;
            WAIT_SENSOR: begin
                if (sensor_valid) begin
                    hs        = 1'b1;
                    state_nxt = CALC_ERR;
                end else if (wcnt == TO_W'(TIMEOUT - 1)) begin
                    to_evt    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            CALC_ERR:    state_nxt = MUL_P;
            MUL_P:       state_nxt = MUL_D;
            MUL_D:       state_nxt = SATURATE;
            SATURATE:    state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
        if (!en) begin
            state_nxt = IDLE;
            hs        = 1'b0;
            to_evt    = 1'b0;
        end
    end

    // Error terms are formed at 33 bits so the 17-bit differences never wrap.
    assign err_wide   = {{(ACC_W-DATA_W){sensor_q[DATA_W-1]}}, sensor_q}
                      - {{(ACC_W-DATA_W){setpoint[DATA_W-1]}}, setpoint};
    assign bias_nxt   = sat_data(err_wide);
    assign d_wide     = {{(ACC_W-DATA_W){bias_nxt[DATA_W-1]}}, bias_nxt}
                      - {{(ACC_W-DATA_W){last_bias[DATA_W-1]}}, last_bias};
    assign d_bias_nxt = first_sample ? '0 : sat_data(d_wide);

    always_comb begin
        mul_a = kp;
        mul_b = bias;
        if (state == MUL_D) begin
            mul_a = kd;
            mul_b = d_bias;
        end
    end

    pd_mul16 u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (prod)
    );

    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign acc_shr  = acc >>> SHIFT;
    assign pwm_nxt  = clamp_pwm(sat_data(acc_shr));

    always_ff @(posedge clk) begin
        if (hs)                sensor_q <= sensor;
        if (state == CALC_ERR) begin
            bias   <= bias_nxt;
            d_bias <= d_bias_nxt;
        end
        if (state == MUL_P)    acc <= prod_ext;
        if (state == MUL_D)    acc <= acc + prod_ext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            wcnt         <= '0;
            first_sample <= 1'b1;
            last_bias    <= '0;
            pwm          <= '0;
            pwm_valid    <= 1'b0;
        end else if (!en) begin
            cnt          <= '0;
            wcnt         <= '0;
            first_sample <= 1'b1;
            pwm          <= '0;
            pwm_valid    <= 1'b0;
        end else begin
            pwm_valid <= 1'b0;
            cnt       <= tick ? '0 : cnt + 1'b1;
            if (state == IDLE)             wcnt <= '0;
            else if (state == WAIT_SENSOR) wcnt <= wcnt + 1'b1;
            if (state == CALC_ERR) begin
                last_bias    <= bias_nxt;
                first_sample <= 1'b0;
            end
            if (state == SATURATE) begin
                pwm       <= pwm_nxt;
                pwm_valid <= 1'b1;
            end
        end
    end

    // A flag-setting event outranks a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_flag <= 1'b0;
            overrun_flag <= 1'b0;
        end else begin
            if (to_evt)         timeout_flag <= 1'b1;
            else if (clr_flags) timeout_flag <= 1'b0;
            if (ov_evt)         overrun_flag <= 1'b1;
            else if (clr_flags) overrun_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pd_loop_sequencer.sv
// Bench for pd_loop_sequencer: two builds driven by shared stimulus, each
// checked every cycle against a transaction-level model, plus literal pins.
module tb_pd_loop_sequencer;

    localparam int NI = 2;
    localparam int PP[NI] = '{8, 4};
    localparam int TT[NI] = '{2, 2};
    localparam int SS[NI] = '{0, 3};
    localparam int MM[NI] = '{7000, 32767};

    logic clk = 1'b0;
    logic rst, en, sensor_valid, clr_flags;
    logic signed [15:0] setpoint, kp, kd, sensor;
    logic sreq_a, pv_a, busy_a, to_a, ov_a;
    logic sreq_b, pv_b, busy_b, to_b, ov_b;
    logic signed [15:0] pwm_a, pwm_b;

    always #5 clk = ~clk;

    pd_loop_sequencer #(.PERIOD(8), .TIMEOUT(2), .SHIFT(0), .PWM_MAX(7000)) dut_a (
        .clk(clk), .rst(rst), .en(en), .setpoint(setpoint), .kp(kp), .kd(kd),
        .sample_req(sreq_a), .sensor_valid(sensor_valid), .sensor(sensor),
        .pwm(pwm_a), .pwm_valid(pv_a), .busy(busy_a), .timeout_flag(to_a),
        .overrun_flag(ov_a), .clr_flags(clr_flags)
    );

    pd_loop_sequencer #(.PERIOD(4), .TIMEOUT(2), .SHIFT(3), .PWM_MAX(32767)) dut_b (
        .clk(clk), .rst(rst), .en(en), .setpoint(setpoint), .kp(kp), .kd(kd),
        .sample_req(sreq_b), .sensor_valid(sensor_valid), .sensor(sensor),
        .pwm(pwm_b), .pwm_valid(pv_b), .busy(busy_b), .timeout_flag(to_b),
        .overrun_flag(ov_b), .clr_flags(clr_flags)
    );

    int n_cmp = 0;
    int n_bad = 0;
    longint cyc = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int     m_cnt[NI], m_age[NI], m_pa[NI];
    bit     m_req[NI], m_pend[NI], m_first[NI], m_pv[NI], m_to[NI], m_ov[NI];
    longint m_pwm[NI], m_last[NI], s_sens[NI], s_sp[NI], s_kp[NI], s_kd[NI];

    function automatic longint sat16(input longint x);
        if (x > 32767)  return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    task automatic model_step(input int i);
        bit busy_pre, tick, set_to, set_ov;
        longint bias, d, acc, sh;
        if (rst) begin
            m_cnt[i] = 0; m_req[i] = 0; m_pend[i] = 0; m_first[i] = 1; m_last[i] = 0;
            m_pwm[i] = 0; m_pv[i] = 0; m_to[i] = 0; m_ov[i] = 0; m_age[i] = 0; m_pa[i] = 0;
            return;
        end
        set_to = 0;
        set_ov = 0;
        m_pv[i] = 0;
        if (!en) begin
            m_cnt[i] = 0; m_req[i] = 0; m_pend[i] = 0; m_first[i] = 1; m_pwm[i] = 0;
        end else begin
            busy_pre = m_req[i] || m_pend[i];
            if (m_pend[i]) begin
                m_pa[i]++;
                if (m_pa[i] == 1)      s_sp[i] = setpoint;
                else if (m_pa[i] == 2) s_kp[i] = kp;
                else if (m_pa[i] == 3) s_kd[i] = kd;
                else begin
                    bias = sat16(s_sens[i] - s_sp[i]);
                    d    = m_first[i] ? 0 : sat16(bias - m_last[i]);
                    m_last[i]  = bias;
                    m_first[i] = 0;
                    acc = s_kp[i] * bias + s_kd[i] * d;
                    sh  = acc >>> SS[i];
                    if (sh > MM[i])       sh = MM[i];
                    else if (sh < -MM[i]) sh = -MM[i];
                    m_pwm[i]  = sh;
                    m_pv[i]   = 1;
                    m_pend[i] = 0;
                end
            end
            if (m_req[i]) begin
                if (sensor_valid) begin
                    m_req[i] = 0; m_pend[i] = 1; m_pa[i] = 0; s_sens[i] = sensor;
                end else begin
                    m_age[i]++;
                    if (m_age[i] == TT[i]) begin
                        m_req[i] = 0;
                        set_to   = 1;
                    end
                end
            end
            tick = (m_cnt[i] == PP[i] - 1);
            m_cnt[i] = tick ? 0 : m_cnt[i] + 1;
            if (tick) begin
                if (busy_pre) set_ov = 1;
                else begin
                    m_req[i] = 1;
                    m_age[i] = 0;
                end
            end
        end
        if (set_to)         m_to[i] = 1;
        else if (clr_flags) m_to[i] = 0;
        if (set_ov)         m_ov[i] = 1;
        else if (clr_flags) m_ov[i] = 0;
    endtask

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < NI; i++) model_step(i);
        #1;
        check("a.sample_req", sreq_a, m_req[0]);
        check("a.busy", busy_a, m_req[0] || m_pend[0]);
        check("a.pwm", pwm_a, m_pwm[0]);
        check("a.pwm_valid", pv_a, m_pv[0]);
        check("a.timeout_flag", to_a, m_to[0]);
        check("a.overrun_flag", ov_a, m_ov[0]);
        check("b.sample_req", sreq_b, m_req[1]);
        check("b.busy", busy_b, m_req[1] || m_pend[1]);
        check("b.pwm", pwm_b, m_pwm[1]);
        check("b.pwm_valid", pv_b, m_pv[1]);
        check("b.timeout_flag", to_b, m_to[1]);
        check("b.overrun_flag", ov_b, m_ov[1]);
    end

    // ---------------- directed + random stimulus ----------------
    function automatic bit pv_of(input int i);
        return (i == 0) ? pv_a : pv_b;
    endfunction
    function automatic bit req_of(input int i);
        return (i == 0) ? sreq_a : sreq_b;
    endfunction
    function automatic longint pwm_of(input int i);
        return (i == 0) ? pwm_a : pwm_b;
    endfunction

    task automatic wait_pub(input string name, input int which, output longint val, output longint lat);
        bit done;
        longint hs;
        done = 0; hs = -1; val = 0; lat = -1;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (pv_of(which)) begin
                done = 1;
                val  = pwm_of(which);
                lat  = cyc - hs;
            end else if (req_of(which) && sensor_valid) begin
                hs = cyc + 1;
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no pwm_valid within 40 cycles", name);
        end
    endtask

    initial begin
        longint v, lat;
        int pv_seen;
        bit ok;
        rst = 1; en = 0; sensor_valid = 1; clr_flags = 0;
        setpoint = 100; kp = 3; kd = 2; sensor = 110;
        repeat (3) @(negedge clk);
        check("reset.pwm", pwm_a, 0);
        check("reset.pwm_valid", pv_a, 0);
        check("reset.sample_req", sreq_a, 0);
        check("reset.busy", busy_a, 0);
        check("reset.timeout_flag", to_a, 0);
        check("reset.overrun_flag", ov_a, 0);
        rst = 0; en = 1;

        wait_pub("first", 0, v, lat);
        check("first.pwm", v, 30);
        check("first.latency", lat, 4);
        sensor = 120;
        wait_pub("deriv", 0, v, lat);
        check("deriv.pwm", v, 80);
        wait_pub("steady", 0, v, lat);
        check("steady.pwm", v, 60);

        kp = 1000; kd = 0; sensor = 200;
        wait_pub("sat_hi", 0, v, lat);
        check("sat_hi.pwm", v, 7000);
        sensor = 0;
        wait_pub("sat_lo", 0, v, lat);
        check("sat_lo.pwm", v, -7000);

        setpoint = -32768; sensor = 32767; kp = 1;
        wait_pub("insat_b0", 1, v, lat);
        wait_pub("insat_b1", 1, v, lat);
        check("insat.b_pwm", v, 4095);
        wait_pub("insat_a", 0, v, lat);
        check("insat.a_pwm", v, 7000);
        check("overrun.a", ov_a, 0);
        check("overrun.b", ov_b, 1);

        sensor_valid = 0;
        ok = 0; pv_seen = 0;
        for (int k = 0; k < 30 && !ok; k++) begin
            @(negedge clk);
            if (pv_a) pv_seen++;
            if (to_a) ok = 1;
        end
        check("timeout.flag", to_a, 1);
        check("timeout.pwm_hold", pwm_a, 7000);
        check("timeout.no_valid", pv_seen, 0);
        clr_flags = 1;
        @(negedge clk);
        clr_flags = 0; sensor_valid = 1;
        check("clr.timeout_flag", to_a, 0);
        wait_pub("after_timeout", 0, v, lat);
        check("after_timeout.pwm", v, 7000);

        setpoint = 100; kp = 3; kd = 2; sensor = 150;
        ok = 0;
        for (int k = 0; k < 30 && !ok; k++) begin
            @(negedge clk);
            if (sreq_a && sensor_valid) ok = 1;
        end
        check("en_drop.handshake_seen", ok, 1);
        @(negedge clk);
        @(negedge clk);
        en = 0;
        @(negedge clk);
        check("en_drop.busy", busy_a, 0);
        check("en_drop.pwm", pwm_a, 0);
        check("en_drop.pwm_valid", pv_a, 0);
        check("en_drop.sample_req", sreq_a, 0);
        sensor = 130; en = 1;
        wait_pub("reenable", 0, v, lat);
        check("reenable.pwm", v, 90);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 39) == 0) en = ~en;
            sensor_valid = ($urandom_range(0, 3) != 0);
            sensor   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 2000)) - 16'd1000;
            setpoint = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 200)) - 16'd100;
            kp       = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 400)) - 16'd200;
            kd       = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 400)) - 16'd200;
            clr_flags = ($urandom_range(0, 15) == 0);
        end
        rst = 0; en = 1; clr_flags = 0;
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
